toggle_activity_monitor: RTL

- Downstream observation stage for the power-experiment sub-circuits. Samples the sub-circuit's primary inputs (n_1..n_4) and its output (n_9) every clock.
- Counts per-signal 0↔1 transitions over a programmable window of cycles.
- Streams the per-signal toggle counts out over a valid/ready handshake, one signal per transfer, for switching-activity and power estimation.

---
 rtl/toggle_activity_monitor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor
// Watches NUM_SIG signals (n_1..n_4 on bits 0..3, n_9 on bit 4) over a
// programmable window. It counts 0<->1 transitions per signal with saturating
// counters, then streams the counts out one signal per valid/ready transfer.
// Optional feature macro: ACT_TOTAL_EN adds res_total, a saturating sum of
// all toggles seen in the window.
module toggle_activity_monitor #(
  parameter int NUM_SIG = 5,
  parameter int CNT_W   = 16,
  parameter int WIN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIN_W-1:0]   window_len,
  input  logic [NUM_SIG-1:0] sig_in,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2:0]         res_idx,
  output logic [CNT_W-1:0]   res_count,
`ifdef ACT_TOTAL_EN
  output logic [CNT_W+2:0]   res_total,
`endif
  output logic               done
);

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN} state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_SIG - 1);

  state_t             state;
  logic [NUM_SIG-1:0] prev;
  logic [WIN_W-1:0]   remaining;
  logic [CNT_W-1:0]   cnt     [NUM_SIG];
  logic [CNT_W-1:0]   cnt_nxt [NUM_SIG];
  logic [NUM_SIG-1:0] toggle;
  logic [2:0]         nxt_idx;
  logic               accept;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic t);
    logic [CNT_W-1:0] r;
    r = c;
    if (t && (c != '1)) r = c + CNT_W'(1);
    return r;
  endfunction

`ifdef ACT_TOTAL_EN
  // Number of signals that toggled this cycle.
  function automatic logic [CNT_W+2:0] popcnt(input logic [NUM_SIG-1:0] v);
    logic [CNT_W+2:0] s;
    s = '0;
    for (int i = 0; i < NUM_SIG; i++) s = s + (CNT_W+3)'(v[i]);
    return s;
  endfunction

  // Wide add that clamps at all-ones on carry out.
  function automatic logic [CNT_W+2:0] sat_add(input logic [CNT_W+2:0] a,
                                               input logic [CNT_W+2:0] b);
    logic [CNT_W+3:0] s;
    logic [CNT_W+2:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = s[CNT_W+3] ? '1 : s[CNT_W+2:0];
    return r;
  endfunction
`endif

  assign toggle  = sig_in ^ prev;
  assign accept  = res_valid && res_ready;
  assign nxt_idx = res_idx + 3'd1;

  // Next value of every per-signal counter for a compared sample.
  always_comb begin
    for (int k = 0; k < NUM_SIG; k++) cnt_nxt[k] = sat_inc(cnt[k], toggle[k]);
  end

  // Control FSM, counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_count <= '0;
      done      <= 1'b0;
      prev      <= '0;
      remaining <= '0;
      for (int k = 0; k < NUM_SIG; k++) cnt[k] <= '0;
`ifdef ACT_TOTAL_EN
      res_total <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (window_len != '0)) begin
            prev      <= sig_in;
            remaining <= window_len;
            busy      <= 1'b1;
            state     <= COUNT;
            for (int k = 0; k < NUM_SIG; k++) cnt[k] <= '0;
`ifdef ACT_TOTAL_EN
            res_total <= '0;
`endif
          end
        end
        COUNT: begin
          prev      <= sig_in;
          remaining <= remaining - WIN_W'(1);
          for (int k = 0; k < NUM_SIG; k++) cnt[k] <= cnt_nxt[k];
`ifdef ACT_TOTAL_EN
          res_total <= sat_add(res_total, popcnt(toggle));
`endif
          // Firing on the last sample keeps remaining from ever wrapping.
          if (remaining == WIN_W'(1)) begin
            state     <= DRAIN;
            res_valid <= 1'b1;
            res_idx   <= '0;
            res_count <= cnt_nxt[0];
          end
        end
        DRAIN: begin
          if (accept) begin
            if (res_idx == LAST_IDX) begin
              res_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              res_idx   <= '0;
              state     <= IDLE;
            end else begin
              res_idx   <= nxt_idx;
              res_count <= cnt[nxt_idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
